// File: rtl/vga_sync_tracker.sv
// Receiver-side sync checker: measures sync pulse width and line period on one axis,
// declares lock after a run of good lines and regenerates the active-region position.
module vga_sync_tracker #(
   parameter int SYNC_PULSE    = 96,
   parameter int BACK_PORCH    = 48,
   parameter int ACTIVE_REGION = 640,
   parameter int FRONT_PORCH   = 16,
   parameter int POS_SIZE      = 9,
   parameter int COUNT_SIZE    = 10,
   parameter int LOCK_LINES    = 3
) (
   input  logic                  pixel_clock,
   input  logic                  reset,
   input  logic                  sync_in,
   output logic [POS_SIZE:0]     pos,
   output logic                  active,
   output logic                  locked,
   output logic                  error,
   output logic [COUNT_SIZE:0]   measured_pulse,
   output logic [COUNT_SIZE:0]   measured_length
);

   localparam int LINE_LENGTH = SYNC_PULSE + BACK_PORCH + ACTIVE_REGION + FRONT_PORCH;
   localparam int ACT_START   = SYNC_PULSE + BACK_PORCH;
   localparam int TIMEOUT     = 2 * LINE_LENGTH;
   localparam int CW          = COUNT_SIZE + 1;
   localparam int PW          = POS_SIZE + 1;

   localparam logic [COUNT_SIZE:0] LINE_LEN_C   = CW'(LINE_LENGTH);
   localparam logic [COUNT_SIZE:0] SYNC_PULSE_C = CW'(SYNC_PULSE);
   localparam logic [COUNT_SIZE:0] ACT_START_C  = CW'(ACT_START);
   localparam logic [COUNT_SIZE:0] ACT_END_C    = CW'(ACT_START + ACTIVE_REGION);
   localparam logic [COUNT_SIZE:0] TIMEOUT_M1_C = CW'(TIMEOUT - 1);
   localparam logic [3:0]          LOCK_LINES_C = 4'(LOCK_LINES);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t              state_q;
   logic                sync_q;
   logic [COUNT_SIZE:0] count_q, count_d, count_inc;
   logic [COUNT_SIZE:0] pulse_q, length_q;
   logic [3:0]          good_q, good_inc;
   logic [POS_SIZE:0]   pos_q, pos_d;
   logic                active_q, locked_q, error_q;
   logic                fall, rise, cnt_max, timeout, line_good, pos_en, in_window;

   always_comb begin
      fall      = sync_q & ~sync_in;
      rise      = ~sync_q & sync_in;
      count_inc = count_q + CW'(1);
      cnt_max   = (count_q == TIMEOUT_M1_C);
      // A fall landing on the last count wins over the timeout
      timeout   = (state_q != HUNT) && cnt_max && !fall;
      line_good = (count_inc == LINE_LEN_C) && (pulse_q == SYNC_PULSE_C);
      good_inc  = good_q + 4'd1;

      count_d = count_inc;
      if (state_q == HUNT || fall || timeout) begin
         count_d = '0;
      end else if (cnt_max) begin
         count_d = count_q;
      end

      pos_en    = (state_q == LOCKED) && !timeout && !(fall && !line_good);
      in_window = (count_d >= ACT_START_C) && (count_d < ACT_END_C);
      pos_d     = PW'(count_d - ACT_START_C);
   end

   always_ff @(posedge pixel_clock or negedge reset) begin
      if (!reset) begin
         state_q  <= HUNT;
         sync_q   <= 1'b0;
         count_q  <= '0;
         good_q   <= '0;
         pulse_q  <= '0;
         length_q <= '0;
         pos_q    <= '1;
         active_q <= 1'b0;
         locked_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         sync_q  <= sync_in;
         count_q <= count_d;
         error_q <= 1'b0;

         if (rise) begin
            pulse_q <= count_inc;
         end

         case (state_q)
            HUNT: begin
               good_q <= '0;
               if (fall) begin
                  state_q <= MEASURE;
               end
            end
            MEASURE: begin
               if (fall) begin
                  length_q <= count_inc;
                  if (line_good) begin
                     good_q <= good_inc;
                     if (good_inc == LOCK_LINES_C) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                     end
                  end else begin
                     good_q  <= '0;
                     error_q <= 1'b1;
                  end
               end else if (timeout) begin
                  state_q  <= HUNT;
                  error_q  <= 1'b1;
                  locked_q <= 1'b0;
                  good_q   <= '0;
               end
            end
            LOCKED: begin
               if (fall) begin
                  length_q <= count_inc;
                  if (!line_good) begin
                     state_q  <= MEASURE;
                     error_q  <= 1'b1;
                     locked_q <= 1'b0;
                     good_q   <= '0;
                  end
               end else if (timeout) begin
                  state_q  <= HUNT;
                  error_q  <= 1'b1;
                  locked_q <= 1'b0;
                  good_q   <= '0;
               end
            end
            default: begin
               state_q  <= HUNT;
               locked_q <= 1'b0;
               good_q   <= '0;
            end
         endcase

         // Position tracks the count being loaded now, so pos=0 lands on the ACT_START sample
         if (pos_en && in_window) begin
            pos_q    <= pos_d;
            active_q <= 1'b1;
         end else begin
            pos_q    <= '1;
            active_q <= 1'b0;
         end
      end
   end

   assign pos             = pos_q;
   assign active          = active_q;
   assign locked          = locked_q;
   assign error           = error_q;
   assign measured_pulse  = pulse_q;
   assign measured_length = length_q;

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Directed bench for vga_sync_tracker: ideal lock, bad pulse, long line, timeout,
// reset with sync held low, and reset mid-line while locked.
module tb_vga_sync_tracker;

   logic        pixel_clock;
   logic        reset;
   logic        sync_in;
   logic [9:0]  pos;
   logic        active;
   logic        locked;
   logic        error;
   logic [10:0] measured_pulse;
   logic [10:0] measured_length;

   int checks = 0;
   int errors = 0;
   int err_pulses = 0;
   int err_mark;
   int cap_idx = -1;

   logic        l0, e0, a144, a784, ca, cl, ce;
   logic [10:0] ml0;
   logic [9:0]  p144, p783, p784, cp;

   vga_sync_tracker dut (
      .pixel_clock     (pixel_clock),
      .reset           (reset),
      .sync_in         (sync_in),
      .pos             (pos),
      .active          (active),
      .locked          (locked),
      .error           (error),
      .measured_pulse  (measured_pulse),
      .measured_length (measured_length)
   );

   initial pixel_clock = 1'b0;
   always #5 pixel_clock = ~pixel_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one sample; outputs are looked at 1 time unit after the sampling edge
   task automatic step(input logic s);
      @(negedge pixel_clock);
      sync_in = s;
      @(posedge pixel_clock);
      #1;
      if (error === 1'b1) err_pulses++;
   endtask

   task automatic drive_line(input int plen, input int llen);
      for (int i = 0; i < llen; i++) begin
         step((i < plen) ? 1'b0 : 1'b1);
         if (i == 0)   begin l0 = locked; e0 = error; ml0 = measured_length; end
         if (i == 144) begin p144 = pos; a144 = active; end
         if (i == 783) p783 = pos;
         if (i == 784) begin p784 = pos; a784 = active; end
         if (i == cap_idx) begin cp = pos; ca = active; cl = locked; ce = error; end
      end
   endtask

   initial begin
      sync_in = 1'b1;
      reset   = 1'b1;
      #3 reset = 1'b0;
      #1;
      chk("rst_pos", pos, 1023);
      chk("rst_active", active, 0);
      chk("rst_locked", locked, 0);
      chk("rst_error", error, 0);
      chk("rst_mpulse", measured_pulse, 0);
      chk("rst_mlength", measured_length, 0);
      for (int i = 0; i < 3; i++) step(1'b1);
      @(negedge pixel_clock);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) step(1'b1);

      // Ideal stream: lock on the 4th fall, position valid in that same line
      err_mark = err_pulses;
      for (int n = 0; n < 3; n++) drive_line(96, 800);
      chk("s1_not_locked_3", locked, 0);
      drive_line(96, 800);
      chk("s1_lock_4th_fall", l0, 1);
      chk("s1_pos144", p144, 0);
      chk("s1_act144", a144, 1);
      chk("s1_pos783", p783, 639);
      chk("s1_pos784", p784, 1023);
      chk("s1_act784", a784, 0);
      chk("s1_mlength", measured_length, 800);
      chk("s1_mpulse", measured_pulse, 96);
      chk("s1_no_error", err_pulses - err_mark, 0);

      // Short pulse of 95 samples
      drive_line(95, 800);
      chk("s2_fall_ok_locked", l0, 1);
      chk("s2_mpulse95", measured_pulse, 95);
      err_mark = err_pulses;
      drive_line(96, 800);
      chk("s2_err_at_fall", e0, 1);
      chk("s2_unlock_at_fall", l0, 0);
      chk("s2_one_err_pulse", err_pulses - err_mark, 1);
      drive_line(96, 800);
      drive_line(96, 800);
      chk("s2_still_unlocked", locked, 0);
      drive_line(96, 800);
      chk("s2_relock", l0, 1);

      // Line stretched to 801 samples
      drive_line(96, 801);
      chk("s3_fall_ok_locked", l0, 1);
      err_mark = err_pulses;
      drive_line(96, 800);
      chk("s3_err_at_fall", e0, 1);
      chk("s3_unlock", l0, 0);
      chk("s3_mlength801", ml0, 801);
      chk("s3_one_err_pulse", err_pulses - err_mark, 1);
      drive_line(96, 800);
      drive_line(96, 800);
      drive_line(96, 800);
      chk("s3_relock", l0, 1);

      // Sync held high until timeout
      err_mark = err_pulses;
      cap_idx = 1600;
      drive_line(96, 1601);
      cap_idx = -1;
      chk("s4_timeout_err", ce, 1);
      chk("s4_timeout_unlock", cl, 0);
      chk("s4_timeout_pos", cp, 1023);
      chk("s4_timeout_act", ca, 0);
      chk("s4_one_err_pulse", err_pulses - err_mark, 1);
      drive_line(96, 800);
      chk("s4_err_one_cycle", e0, 0);
      drive_line(96, 800);
      drive_line(96, 800);
      chk("s4_not_locked_3", locked, 0);
      drive_line(96, 800);
      chk("s4_relock_4th", l0, 1);

      // Reset at index 300 of a locked line
      cap_idx = 300;
      drive_line(96, 301);
      cap_idx = -1;
      chk("s6_pos300", cp, 156);
      chk("s6_act300", ca, 1);
      chk("s6_locked300", cl, 1);
      reset = 1'b0;
      #1;
      chk("s6_rst_pos", pos, 1023);
      chk("s6_rst_active", active, 0);
      chk("s6_rst_locked", locked, 0);
      chk("s6_rst_mlength", measured_length, 0);
      chk("s6_rst_mpulse", measured_pulse, 0);

      // Sync held low through reset release, then the ideal stream
      for (int i = 0; i < 5; i++) step(1'b0);
      @(negedge pixel_clock);
      reset = 1'b1;
      err_mark = err_pulses;
      for (int i = 0; i < 50; i++) step(1'b0);
      chk("s5_low_no_lock", locked, 0);
      drive_line(96, 800);
      drive_line(96, 800);
      drive_line(96, 800);
      drive_line(96, 800);
      chk("s5_not_locked_3_falls", locked, 0);
      drive_line(96, 800);
      chk("s5_lock_4th_fall", l0, 1);
      chk("s5_pos144", p144, 0);
      chk("s5_act144", a144, 1);
      chk("s5_pos783", p783, 639);
      chk("s5_pos784", p784, 1023);
      chk("s5_act784", a784, 0);
      chk("s5_mlength", measured_length, 800);
      chk("s5_no_error", err_pulses - err_mark, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_sync_tracker.md
# vga_sync_tracker

Receiver-side counterpart to the display sync generator. It watches an incoming active-low sync stream, one axis per instance (HSync by default), and measures the pulse width and period of each line. After a run of correct lines it declares lock, then regenerates the active-region position locally. It sits at the capture or self-check end of the VGA path, for example looped back from the generator's sync output, and flags any timing violation.

## Interface
- SYNC_PULSE, 96, expected sync-low length in pixel clocks
- BACK_PORCH, 48, expected back-porch length
- ACTIVE_REGION, 640, expected active video length
- FRONT_PORCH, 16, expected front-porch length
- POS_SIZE, 9, pos is POS_SIZE+1 bits wide
- COUNT_SIZE, 10, internal counter and measurement outputs are COUNT_SIZE+1 bits wide; must hold 2*LINE_LENGTH
- LOCK_LINES, 3, consecutive good lines required for lock, range 1..15
- Derived: LINE_LENGTH = sum of the four regions (800); ACT_START = SYNC_PULSE+BACK_PORCH (144); TIMEOUT = 2*LINE_LENGTH (1600)
- pixel_clock  in  1  pixel clock; all logic on posedge
- reset  in  1  asynchronous, active-low
- sync_in  in  1  incoming sync, low during pulse
- pos  out  POS_SIZE+1  active-region position while locked; otherwise all-ones
- active  out  1  high when pos is valid
- locked  out  1  timing lock
- error  out  1  one-cycle pulse on a violation or timeout
- measured_pulse  out  COUNT_SIZE+1  last captured sync-low width
- measured_length  out  COUNT_SIZE+1  last captured line length

## Operation
- sync_d registers sync_in.
  - fall = sync_d & ~sync_in
  - rise = ~sync_d & sync_in
- count is the sample index relative to the most recent fall sample.
  - fall sets count to 0.
  - Otherwise count increments, saturating at TIMEOUT-1.
- On rise: measured_pulse <= count+1.
- On fall, except in HUNT: measured_length <= count+1.
- A line is **good** when, at fall, count+1 == LINE_LENGTH and measured_pulse == SYNC_PULSE. Use the value of measured_pulse stored before that edge.
- State machine, 2-bit:
  - HUNT (reset state): count and good_lines are held at 0. On fall, go to MEASURE.
  - MEASURE: on each fall, if the line is good, good_lines++. When the incremented value equals LOCK_LINES, go to LOCKED and set locked=1. If the line is bad, set good_lines=0, pulse error, and stay in MEASURE.
  - LOCKED: on a good fall, stay in LOCKED. On a bad fall, pulse error, set locked=0 and good_lines=0, and go to MEASURE.
  - Timeout: in MEASURE or LOCKED, when count reaches TIMEOUT-1 with no fall, go to HUNT, pulse error, and clear locked and good_lines.
- Position, in LOCKED only, using next_count (the count value being loaded at this edge):
  - If ACT_START <= next_count < ACT_START+ACTIVE_REGION: pos <= next_count-ACT_START and active <= 1.
  - Otherwise pos <= all-ones and active <= 0.
  - In HUNT and MEASURE: pos is all-ones and active is 0.
- The subtraction is computed at COUNT_SIZE+1 bits and truncated to POS_SIZE+1 bits.
- A fall that coincides with count==TIMEOUT-1 is treated as a fall; no timeout occurs.

## Timing
- All outputs are registered and update on the posedge at which the sampled event is seen.
- error is high for exactly one cycle after the deciding edge.
- locked rises on the same posedge as the LOCK_LINES-th good fall.
- The LOCKED transition happens on the fall that starts a line. pos is therefore valid from ACT_START of that same line.
- pos/active lag sync_in by one register stage relative to the sampled index. pos=0 appears at the posedge that samples index ACT_START.
- Asynchronous reset values:
  - State: HUNT
  - sync_d: 0, so a sync held low through reset release is not an edge
  - count, good_lines, measured_pulse, measured_length: 0
  - pos: all-ones
  - active, locked, error: 0
- Reset mid-line or while locked forces every output to its reset value immediately. Reacquisition then requires 1+LOCK_LINES falls.

## Test plan
- Reset, then drive an ideal 96/48/640/16 stream: locked rises at the 4th fall. On the next lines, pos=0 at index 144 and pos=639 at index 783; at index 784 pos=1023 and active=0. measured_length=800 and measured_pulse=96.
- While locked, shorten one pulse to 95 samples: at the following fall, error pulses once and locked drops. locked returns after 3 further good lines. measured_pulse=95 during the bad line.
- While locked, stretch one line to 801: error pulses and locked drops at that fall. measured_length=801.
- While locked, hold sync_in high for 1600 samples: at count 1599 the block enters HUNT, error pulses, locked=0, pos=1023. Resuming the stream relocks after 4 falls.
- Hold sync_in low through reset release for 50 cycles, then start the ideal stream: no error. Lock occurs only after 4 genuine high-to-low transitions.
- Assert reset at index 300 of a locked line: pos=1023, active=0, locked=0 immediately. After release, the block behaves as in the first scenario.
